// File: rtl/eth_mac_tx_ptp_tagger_if.sv
// rtl/eth_mac_tx_ptp_tagger_if.sv - AXI-stream bundle used for the tagger's frame input and MAC-side output
interface eth_mac_tx_ptp_tagger_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic                  tvalid;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tready;

    modport master (output tdata, tkeep, tlast, tvalid, tuser, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, tuser, output tready);
endinterface

// File: rtl/eth_mac_tx_ptp_tagger.sv
// rtl/eth_mac_tx_ptp_tagger.sv - tags outgoing frames and matches returned PTP timestamps in order
module eth_mac_tx_ptp_tagger #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int PTP_TS_WIDTH    = 96,
    parameter int PTP_TAG_WIDTH   = 16,
    parameter int DEPTH           = 16,
    parameter int TIMEOUT         = 4096
) (
    input  logic                       tx_clk,
    input  logic                       tx_rst,
    eth_mac_tx_ptp_tagger_if.slave     s_axis,
    eth_mac_tx_ptp_tagger_if.master    tx_axis,
    input  logic [PTP_TS_WIDTH-1:0]    tx_ptp_ts,
    input  logic [PTP_TAG_WIDTH-1:0]   tx_ptp_ts_tag,
    input  logic                       tx_ptp_ts_valid,
    output logic [PTP_TS_WIDTH-1:0]    m_axis_ts,
    output logic [PTP_TAG_WIDTH-1:0]   m_axis_ts_tag,
    output logic                       m_axis_ts_valid,
    input  logic                       m_axis_ts_ready,
    output logic [$clog2(DEPTH):0]     pending_count,
    output logic                       stat_ts_mismatch,
    output logic                       stat_ts_timeout,
    output logic                       stat_ts_overflow
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int AGE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit   TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

    state_t                   state_q;
    logic [PTP_TAG_WIDTH-1:0] tag_cnt_q;
    logic [PTP_TAG_WIDTH-1:0] frame_tag_q;

    logic [PTP_TAG_WIDTH-1:0] q_tag_q [DEPTH];
    logic                     q_req_q [DEPTH];
    logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]            count_q, count_d;
    logic [AGE_W-1:0]         age_q, age_d;

    logic [PTP_TS_WIDTH-1:0]  ts_q;
    logic [PTP_TAG_WIDTH-1:0] ts_tag_q;
    logic                     ts_valid_q;
    logic                     mismatch_q, timeout_q, overflow_q;

    logic [AXIS_DATA_WIDTH-1:0] data_w;
    logic [AXIS_KEEP_WIDTH-1:0] keep_w;
    logic stall, s_hs, push, pop, empty, ts_match, ts_mismatch, ts_timeout, ts_load, ts_overflow;

    // Pass-through data path; only a first beat can be held back by a full queue
    assign data_w          = s_axis.tdata;
    assign keep_w          = s_axis.tkeep;
    assign tx_axis.tdata   = data_w;
    assign tx_axis.tkeep   = keep_w;
    assign tx_axis.tlast   = s_axis.tlast;
    assign stall           = (state_q == IDLE) && (count_q == CW'(DEPTH));
    assign tx_axis.tvalid  = s_axis.tvalid && !stall;
    assign s_axis.tready   = tx_axis.tready && !stall;
    assign tx_axis.tuser   = {(state_q == FRAME) ? frame_tag_q : tag_cnt_q, s_axis.tuser[0]};

    assign s_hs  = s_axis.tvalid && tx_axis.tready && !stall;
    assign push  = s_hs && (state_q == IDLE);
    assign empty = (count_q == '0);

    // Returned timestamps are only ever compared against the oldest outstanding tag
    assign ts_match    = tx_ptp_ts_valid && !empty && (tx_ptp_ts_tag == q_tag_q[rd_ptr_q]);
    assign ts_mismatch = tx_ptp_ts_valid && !ts_match;
    assign ts_timeout  = TIMEOUT_EN && !empty && !ts_match && (age_q == AGE_LIMIT);
    assign ts_load     = ts_match && q_req_q[rd_ptr_q] && (!ts_valid_q || m_axis_ts_ready);
    assign ts_overflow = ts_match && q_req_q[rd_ptr_q] && ts_valid_q && !m_axis_ts_ready;
    assign pop         = ts_match || ts_timeout;

    // Occupancy and head age next-state
    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
        age_d = (empty || pop) ? '0 : age_q + 1'b1;
    end

    // Frame FSM: first-beat detection, tag latch and tag counter
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state_q     <= IDLE;
            tag_cnt_q   <= '0;
            frame_tag_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (s_hs) begin
                    tag_cnt_q   <= tag_cnt_q + 1'b1;
                    frame_tag_q <= tag_cnt_q;
                    if (!s_axis.tlast)
                        state_q <= FRAME;
                end
                FRAME: if (s_hs && s_axis.tlast)
                    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pending queue entry storage, never read while empty
    always_ff @(posedge tx_clk) begin
        if (push) begin
            q_tag_q[wr_ptr_q] <= tag_cnt_q;
            q_req_q[wr_ptr_q] <= s_axis.tuser[1];
        end
    end

    // Pending queue pointers, occupancy and head age
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            age_q    <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            age_q   <= age_d;
        end
    end

    // Timestamp output register and one-cycle status pulses
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            ts_q       <= '0;
            ts_tag_q   <= '0;
            ts_valid_q <= 1'b0;
            mismatch_q <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (ts_load) begin
                ts_q       <= tx_ptp_ts;
                ts_tag_q   <= tx_ptp_ts_tag;
                ts_valid_q <= 1'b1;
            end else if (m_axis_ts_ready) begin
                ts_valid_q <= 1'b0;
            end
            mismatch_q <= ts_mismatch;
            timeout_q  <= ts_timeout;
            overflow_q <= ts_overflow;
        end
    end

    assign m_axis_ts        = ts_q;
    assign m_axis_ts_tag    = ts_tag_q;
    assign m_axis_ts_valid  = ts_valid_q;
    assign pending_count    = count_q;
    assign stat_ts_mismatch = mismatch_q;
    assign stat_ts_timeout  = timeout_q;
    assign stat_ts_overflow = overflow_q;
endmodule

// File: tb/tb_eth_mac_tx_ptp_tagger.sv
// tb/tb_eth_mac_tx_ptp_tagger.sv - directed and random checks of the PTP tagger against a queue model
module tb_eth_mac_tx_ptp_tagger;
    localparam int DW = 64, KW = 8, TSW = 96, TGW = 16, DEPTH = 16, TIMEOUT = 32;

    logic           tx_clk = 1'b0;
    logic           tx_rst = 1'b1;
    logic [TSW-1:0] tx_ptp_ts = '0;
    logic [TGW-1:0] tx_ptp_ts_tag = '0;
    logic           tx_ptp_ts_valid = 1'b0;
    logic [TSW-1:0] m_axis_ts;
    logic [TGW-1:0] m_axis_ts_tag;
    logic           m_axis_ts_valid;
    logic           m_axis_ts_ready = 1'b1;
    logic [4:0]     pending_count;
    logic           stat_ts_mismatch, stat_ts_timeout, stat_ts_overflow;

    eth_mac_tx_ptp_tagger_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(2))       s_axis ();
    eth_mac_tx_ptp_tagger_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(TGW + 1)) tx_axis ();

    eth_mac_tx_ptp_tagger #(
        .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .PTP_TS_WIDTH(TSW),
        .PTP_TAG_WIDTH(TGW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .tx_clk(tx_clk), .tx_rst(tx_rst), .s_axis(s_axis), .tx_axis(tx_axis),
        .tx_ptp_ts(tx_ptp_ts), .tx_ptp_ts_tag(tx_ptp_ts_tag), .tx_ptp_ts_valid(tx_ptp_ts_valid),
        .m_axis_ts(m_axis_ts), .m_axis_ts_tag(m_axis_ts_tag), .m_axis_ts_valid(m_axis_ts_valid),
        .m_axis_ts_ready(m_axis_ts_ready), .pending_count(pending_count),
        .stat_ts_mismatch(stat_ts_mismatch), .stat_ts_timeout(stat_ts_timeout),
        .stat_ts_overflow(stat_ts_overflow)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct { int tag; bit req; } pend_t;

    pend_t          mq[$];
    int             got_tags[$];
    int             m_tag_cnt, m_frame_tag, m_age;
    bit             m_in_frame, m_ov, exp_mis, exp_to, exp_ovf, last_hs;
    logic [TSW-1:0] m_ts;
    logic [TGW-1:0] m_tstag;
    int             n_total = 0, n_bad = 0;
    int             cnt_mis, cnt_to, cnt_ovf;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_tag_cnt = 0; m_frame_tag = 0; m_age = 0; m_in_frame = 0;
        m_ov = 0; m_ts = '0; m_tstag = '0;
        exp_mis = 0; exp_to = 0; exp_ovf = 0;
    endtask

    // One clock: inputs already set after a falling edge; check, advance model, wait for next falling edge
    task automatic cycle();
        bit stall_m, hs, first, popped, load, mis, to, ovf;
        #1;
        stall_m = !m_in_frame && (mq.size() == DEPTH);
        check_eq("s_tready", s_axis.tready, tx_axis.tready && !stall_m);
        check_eq("tx_tvalid", tx_axis.tvalid, s_axis.tvalid && !stall_m);
        if (s_axis.tvalid && !stall_m) begin
            check_eq("tx_tdata", tx_axis.tdata, s_axis.tdata);
            check_eq("tx_tkeep", tx_axis.tkeep, s_axis.tkeep);
            check_eq("tx_tlast", tx_axis.tlast, s_axis.tlast);
            check_eq("tx_tuser", tx_axis.tuser,
                     {TGW'(m_in_frame ? m_frame_tag : m_tag_cnt), s_axis.tuser[0]});
        end
        check_eq("pending", pending_count, mq.size());
        check_eq("m_valid", m_axis_ts_valid, m_ov);
        check_eq("m_ts", m_axis_ts, m_ts);
        check_eq("m_tag", m_axis_ts_tag, m_tstag);
        check_eq("st_mis", stat_ts_mismatch, exp_mis);
        check_eq("st_to", stat_ts_timeout, exp_to);
        check_eq("st_ovf", stat_ts_overflow, exp_ovf);
        if (m_axis_ts_valid === 1'b1 && m_axis_ts_ready) got_tags.push_back(int'(m_axis_ts_tag));
        cnt_mis += int'(stat_ts_mismatch === 1'b1);
        cnt_to  += int'(stat_ts_timeout === 1'b1);
        cnt_ovf += int'(stat_ts_overflow === 1'b1);

        hs = s_axis.tvalid && tx_axis.tready && !stall_m;
        first = hs && !m_in_frame;
        if (tx_rst) begin
            model_reset();
            last_hs = 0;
        end else begin
            mis = 0; to = 0; ovf = 0; popped = 0; load = 0;
            if (tx_ptp_ts_valid) begin
                if (mq.size() == 0 || mq[0].tag != int'(tx_ptp_ts_tag)) mis = 1;
                else begin
                    popped = 1;
                    if (mq[0].req) begin
                        if (!m_ov || m_axis_ts_ready) load = 1;
                        else ovf = 1;
                    end
                end
            end
            if (!popped && TIMEOUT != 0 && mq.size() > 0 && m_age == TIMEOUT - 1) begin
                popped = 1; to = 1;
            end
            if (mq.size() == 0 || popped) m_age = 0;
            else m_age++;
            if (load) begin
                m_ov = 1; m_ts = tx_ptp_ts; m_tstag = tx_ptp_ts_tag;
            end else if (m_axis_ts_ready) m_ov = 0;
            if (popped) void'(mq.pop_front());
            if (first) begin
                mq.push_back('{tag: m_tag_cnt, req: s_axis.tuser[1]});
                m_frame_tag = m_tag_cnt;
                m_tag_cnt = (m_tag_cnt + 1) % 65536;
            end
            if (hs) m_in_frame = !s_axis.tlast;
            exp_mis = mis; exp_to = to; exp_ovf = ovf;
            last_hs = hs;
        end
        @(negedge tx_clk);
    endtask

    task automatic send_beat(input bit last, input bit req, input bit bad);
        bit done = 0;
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = {$urandom, $urandom};
        s_axis.tkeep  = KW'($urandom);
        s_axis.tlast  = last;
        s_axis.tuser  = {req, bad};
        for (int k = 0; k < 200 && !done; k++) begin
            cycle();
            tx_ptp_ts_valid = 1'b0;
            done = last_hs;
        end
        if (!done) check_eq("beat_wait", 0, 1);
        s_axis.tvalid = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit req, input bit bad);
        for (int b = 0; b < n; b++) send_beat(b == n - 1, req, bad);
    endtask

    task automatic return_ts(input int tag);
        tx_ptp_ts_valid = 1'b1;
        tx_ptp_ts       = {$urandom, $urandom, $urandom};
        tx_ptp_ts_tag   = TGW'(tag);
        cycle();
        tx_ptp_ts_valid = 1'b0;
    endtask

    task automatic do_reset();
        tx_rst = 1'b1;
        s_axis.tvalid = 1'b0;
        tx_ptp_ts_valid = 1'b0;
        cycle();
        tx_rst = 1'b0;
        cnt_mis = 0; cnt_to = 0; cnt_ovf = 0;
        got_tags.delete();
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit offering = 0, cur_req = 0, cur_bad = 0;
        int beats_left = 0, r;
        s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tkeep = '0;
        s_axis.tlast = 1'b0; s_axis.tuser = '0; tx_axis.tready = 1'b1;
        repeat (3) @(negedge tx_clk);
        tx_rst = 1'b0;
        model_reset();
        cnt_mis = 0; cnt_to = 0; cnt_ovf = 0;
        #1;
        check_eq("rst_pending", pending_count, 0);
        check_eq("rst_mvalid", m_axis_ts_valid, 0);
        check_eq("rst_mts", m_axis_ts, 0);
        check_eq("rst_mtag", m_axis_ts_tag, 0);
        check_eq("rst_stats", {stat_ts_mismatch, stat_ts_timeout, stat_ts_overflow}, 0);
        check_eq("rst_tag", tx_axis.tuser[TGW:1], 0);

        // in-order tags
        send_frame(1, 1, 0); send_frame(3, 0, 1); send_frame(8, 1, 0);
        return_ts(0); return_ts(1); return_ts(2);
        repeat (2) cycle();
        check_eq("ord_n", got_tags.size(), 2);
        if (got_tags.size() == 2) begin
            check_eq("ord_t0", got_tags[0], 0);
            check_eq("ord_t1", got_tags[1], 2);
        end
        check_eq("ord_pend", pending_count, 0);

        // full stall
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_frame(1, 0, 0);
        s_axis.tvalid = 1'b1; s_axis.tlast = 1'b1; s_axis.tuser = 2'b00;
        #1;
        check_eq("full_tready", s_axis.tready, 0);
        check_eq("full_pend", pending_count, 16);
        return_ts(0);
        #1;
        check_eq("rel_tready", s_axis.tready, 1);
        check_eq("rel_pend", pending_count, 15);
        cycle();
        s_axis.tvalid = 1'b0;
        while (mq.size() > 0) return_ts(mq[0].tag);

        // mismatch
        do_reset();
        for (int i = 0; i < 5; i++) begin send_frame(1, 0, 0); return_ts(i); end
        send_frame(2, 1, 0);
        return_ts(7); cycle();
        check_eq("mis_pulse", cnt_mis, 1);
        check_eq("mis_pend", pending_count, 1);
        return_ts(5); cycle();
        check_eq("mis_fwd_n", got_tags.size(), 1);
        if (got_tags.size() == 1) check_eq("mis_fwd_tag", got_tags[0], 5);

        // timeout, then a late timestamp is an orphan
        do_reset();
        send_frame(1, 1, 0);
        repeat (40) cycle();
        check_eq("to_pulse", cnt_to, 1);
        check_eq("to_pend", pending_count, 0);
        return_ts(0); cycle();
        check_eq("to_late_mis", cnt_mis, 1);

        // overflow
        do_reset();
        m_axis_ts_ready = 1'b0;
        send_frame(1, 1, 0); send_frame(1, 1, 0);
        return_ts(0); return_ts(1); cycle();
        check_eq("ovf_pulse", cnt_ovf, 1);
        check_eq("ovf_hold_tag", m_axis_ts_tag, 0);
        check_eq("ovf_hold_valid", m_axis_ts_valid, 1);
        m_axis_ts_ready = 1'b1;
        repeat (2) cycle();

        // reset mid-frame
        m_axis_ts_ready = 1'b0;
        send_frame(1, 1, 0);
        return_ts(mq[0].tag);
        send_beat(0, 1, 0);
        tx_rst = 1'b1; cycle(); tx_rst = 1'b0;
        m_axis_ts_ready = 1'b1;
        #1;
        check_eq("mid_rst_valid", m_axis_ts_valid, 0);
        check_eq("mid_rst_ts", m_axis_ts, 0);
        check_eq("mid_rst_pend", pending_count, 0);
        s_axis.tvalid = 1'b1; s_axis.tlast = 1'b1; s_axis.tuser = 2'b00;
        #1;
        check_eq("mid_rst_tag", tx_axis.tuser[TGW:1], 0);
        cycle();
        s_axis.tvalid = 1'b0;

        // tag wrap: run the counter up to 0xFFFF with back-to-back returns
        do_reset();
        s_axis.tvalid = 1'b1; s_axis.tlast = 1'b1; s_axis.tuser = 2'b00;
        for (int i = 0; i < 65535; i++) begin
            tx_ptp_ts_valid = (mq.size() > 0);
            if (mq.size() > 0) tx_ptp_ts_tag = TGW'(mq[0].tag);
            cycle();
        end
        tx_ptp_ts_valid = 1'b1; tx_ptp_ts_tag = TGW'(mq[0].tag);
        #1;
        check_eq("wrap_ffff", tx_axis.tuser[TGW:1], 16'hFFFF);
        cycle();
        tx_ptp_ts_tag = TGW'(mq[0].tag);
        #1;
        check_eq("wrap_0000", tx_axis.tuser[TGW:1], 0);
        cycle();
        s_axis.tvalid = 1'b0; tx_ptp_ts_valid = 1'b0;

        // random traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (!offering && $urandom_range(0, 3) != 0) begin
                offering = 1;
                if (beats_left == 0) begin
                    beats_left = $urandom_range(1, 4);
                    cur_req = 1'($urandom); cur_bad = 1'($urandom);
                end
            end
            s_axis.tvalid = offering;
            s_axis.tdata  = {$urandom, $urandom};
            s_axis.tkeep  = KW'($urandom);
            s_axis.tlast  = (beats_left == 1);
            s_axis.tuser  = {cur_req, cur_bad};
            tx_axis.tready  = ($urandom_range(0, 4) != 0);
            m_axis_ts_ready = ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 9);
            tx_ptp_ts       = {$urandom, $urandom, $urandom};
            tx_ptp_ts_valid = (r < 4 && mq.size() > 0) || r == 4;
            tx_ptp_ts_tag   = (r < 4 && mq.size() > 0) ? TGW'(mq[0].tag) : TGW'($urandom);
            cycle();
            if (last_hs) begin beats_left--; offering = 0; end
        end
        tx_axis.tready = 1'b1; m_axis_ts_ready = 1'b1;
        do_reset();
        cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
